// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered binary-to-one-hot decoder.
// Direct mode decodes an accepted sel. Scan mode sweeps the active bit
// through every position, holding each index for SCAN_DIV cycles, and
// pulses scan_wrap_o when the sweep returns to index 0.
// ACTIVE_LOW inverts only the y_o pattern; y_valid_o and scan_wrap_o are
// always active-high.
module onehot_decoder_seq #(
  parameter int SEL_W      = 3,     // legal 1..6
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int SCAN_DIV   = 4,     // legal 1..65535
  localparam int OUT_W     = 2**SEL_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sel_valid_i,
  output logic             sel_ready_o,
  output logic [OUT_W-1:0] y_o,
  output logic             y_valid_o,
  output logic [SEL_W-1:0] scan_idx_o,
  output logic             scan_wrap_o
);

  localparam logic [15:0]      DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  // Per-lane update request shared by every output bit.
  typedef struct packed {
    logic             clr;  // drive the inactive level
    logic             ld;   // load decode(idx)
    logic [SEL_W-1:0] idx;
  } lane_ctl_t;

  state_t           state_q;
  logic [15:0]      div_q;
  logic [SEL_W-1:0] scan_idx_q;
  logic             wrap_q;
  logic             y_valid_q;
  logic [OUT_W-1:0] y_q;
  lane_ctl_t        ctl_d;
  logic             accept;
  logic             roll;

  // Ready depends on inputs only, so it is valid before the edge.
  assign sel_ready_o = en_i & ~mode_i & ~rst_i;
  assign accept      = sel_valid_i & sel_ready_o;
  assign roll        = (div_q == DIV_LAST);

  // Next-value request for the output lanes, priority rst > en > mode.
  always_comb begin
    ctl_d = '0;
    if (rst_i || !en_i) begin
      ctl_d.clr = 1'b1;
    end else begin
      case (state_q)
        SCAN: begin
          if (!mode_i) begin
            ctl_d.clr = 1'b1;
          end else if (roll) begin
            ctl_d.ld  = 1'b1;
            ctl_d.idx = scan_idx_q + 1'b1;  // natural wrap at OUT_W
          end
        end
        default: begin
          if (mode_i) begin
            ctl_d.ld  = 1'b1;
            ctl_d.idx = '0;                 // scan entry beats a pending sel
          end else if (accept) begin
            ctl_d.ld  = 1'b1;
            ctl_d.idx = sel_i;
          end
        end
      endcase
    end
  end

  // Control FSM: state, scan divider/index, wrap pulse and y_valid.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      scan_idx_q <= '0;
      wrap_q     <= 1'b0;
      y_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (!mode_i) begin
            state_q    <= IDLE;
            div_q      <= '0;
            scan_idx_q <= '0;
            wrap_q     <= 1'b0;
            y_valid_q  <= 1'b0;
          end else begin
            wrap_q <= roll && (scan_idx_q == IDX_LAST);
            if (roll) begin
              div_q      <= '0;
              scan_idx_q <= scan_idx_q + 1'b1;
            end else begin
              div_q <= div_q + 16'd1;
            end
          end
        end
        default: begin
          wrap_q <= 1'b0;
          if (mode_i) begin
            state_q    <= SCAN;
            div_q      <= '0;
            scan_idx_q <= '0;
            y_valid_q  <= 1'b1;
          end else if (accept) begin
            state_q   <= DIRECT;
            y_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // One registered flop per output bit; each lane compares the requested
  // index against its own position so y never glitches.
  for (genvar i = 0; i < OUT_W; i++) begin : g_lane
    // Lane i: inactive on clear, decode on load, otherwise hold.
    always_ff @(posedge clk_i) begin
      if (ctl_d.clr) y_q[i] <= ACTIVE_LOW;
      else if (ctl_d.ld) y_q[i] <= (ctl_d.idx == SEL_W'(i)) ^ ACTIVE_LOW;
    end
  end

  assign y_o         = y_q;
  assign y_valid_o   = y_valid_q;
  assign scan_idx_o  = scan_idx_q;
  assign scan_wrap_o = wrap_q;

endmodule
